// File: rtl/usb_bit_destuff_rx_pkg.sv
// Shared types and constants for the USB receive bit destuffer.
package usb_rx_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } rx_state_t;

  localparam logic [7:0]          SYNC_PAT  = 8'b0111_1110;
  localparam int unsigned         ONES_W    = 3;
  localparam logic [ONES_W-1:0]   STUFF_RUN = 3'd6;

endpackage

// File: rtl/usb_bit_destuff_rx_if.sv
// Serial-in / parallel-out bundle of the USB receive bit destuffer.
interface usb_bit_destuff_rx_if #(
  parameter int unsigned DATA_W = 16
);
  logic              serial_in;
  logic              serial_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              sync_detect;
  logic              stuff_err;
  logic              frame_done;
  logic              busy;

  modport master (
    output serial_in, serial_valid,
    input  data_out, data_valid, sync_detect, stuff_err, frame_done, busy
  );

  modport slave (
    input  serial_in, serial_valid,
    output data_out, data_valid, sync_detect, stuff_err, frame_done, busy
  );
endinterface

// File: rtl/usb_bit_destuff_rx_nrzi.sv
// NRZI line decoder: 1 when the line holds its previous sampled level.
// Only built when USB_RX_NRZI_DECODE_EN is defined.
`ifdef USB_RX_NRZI_DECODE_EN
module usb_nrzi_decoder (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  input  logic line_valid,
  output logic bit_out
);
  logic prev_level;

  // Idle J level is 1, so the first sampled bit decodes against 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_level <= 1'b1;
    end else if (line_valid) begin
      prev_level <= line_in;
    end
  end

  assign bit_out = (line_in == prev_level);
endmodule
`endif

// File: rtl/usb_bit_destuff_rx.sv
// USB receive path: SYNC hunt, zero-bit destuffing and LSB-first word assembly.
// Optional NRZI front end when USB_RX_NRZI_DECODE_EN is defined.
module usb_bit_destuff_rx
  import usb_rx_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_FRAME = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 STUFF_OPER_rx,
  usb_bit_destuff_rx_if.slave  bus
);
  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WCNT_W = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

  rx_state_t         state;
  logic [6:0]        hunt;
  logic [ONES_W-1:0] ones_cnt;
  logic [ONES_W-1:0] ones_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [WCNT_W-1:0] word_cnt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              sync_detect_q;
  logic              stuff_err_q;
  logic              frame_done_q;
  logic              rx_bit;
  logic              stuff_pos;

`ifdef USB_RX_NRZI_DECODE_EN
  usb_nrzi_decoder u_nrzi (
    .clk        (clk),
    .rst        (rst),
    .line_in    (bus.serial_in),
    .line_valid (bus.serial_valid),
    .bit_out    (rx_bit)
  );
`else
  assign rx_bit = bus.serial_in;
`endif

  always_comb begin
    ones_next = '0;
    if (rx_bit) begin
      ones_next = (ones_cnt == STUFF_RUN) ? STUFF_RUN : ones_cnt + 1'b1;
    end
  end

  // Word including the current bit, so the completing edge can load data_out.
  always_comb begin
    word_next          = word;
    word_next[bit_idx] = rx_bit;
  end

  assign stuff_pos = STUFF_OPER_rx && (ones_cnt == STUFF_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      hunt          <= '0;
      ones_cnt      <= '0;
      bit_idx       <= '0;
      word_cnt      <= '0;
      word          <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      sync_detect_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      sync_detect_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      if (bus.serial_valid) begin
        case (state)
          HUNT: begin
            if ({hunt, rx_bit} == SYNC_PAT) begin
              sync_detect_q <= 1'b1;
              state         <= DATA;
              hunt          <= '0;
              ones_cnt      <= '0;
              bit_idx       <= '0;
              word_cnt      <= '0;
            end else begin
              hunt <= {hunt[5:0], rx_bit};
            end
          end
          DATA: begin
            if (stuff_pos) begin
              if (rx_bit) begin
                stuff_err_q <= 1'b1;
                state       <= HUNT;
                ones_cnt    <= '0;
                bit_idx     <= '0;
                word_cnt    <= '0;
                word        <= '0;
              end else begin
                ones_cnt <= '0;
              end
            end else begin
              word     <= word_next;
              ones_cnt <= ones_next;
              if (bit_idx == LAST_IDX) begin
                bit_idx      <= '0;
                data_out_q   <= word_next;
                data_valid_q <= 1'b1;
                if (word_cnt == LAST_WORD) begin
                  frame_done_q <= 1'b1;
                  state        <= HUNT;
                  ones_cnt     <= '0;
                  word_cnt     <= '0;
                end else begin
                  word_cnt <= word_cnt + 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.sync_detect = sync_detect_q;
  assign bus.stuff_err   = stuff_err_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = (state == DATA);
endmodule

// File: tb/tb_usb_bit_destuff_rx.sv
// Self-checking bench for usb_bit_destuff_rx: directed cases plus random frames
// built by a transmit-side stuffing encoder and checked through a scoreboard.
module tb_usb_bit_destuff_rx;
  localparam int DW  = 16;
  localparam int WPF = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stuff_oper = 1'b1;

  usb_bit_destuff_rx_if #(.DATA_W(DW)) bus ();

  usb_bit_destuff_rx #(.DATA_W(DW), .WORDS_PER_FRAME(WPF)) dut (
    .clk           (clk),
    .rst           (rst),
    .STUFF_OPER_rx (stuff_oper),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and random-phase scoreboard, sampled on the falling edge.
  int n_dv = 0, n_sync = 0, n_err = 0, n_fd = 0;
  logic mon_en = 1'b0;
  logic [16:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.data_valid)  n_dv++;
      if (bus.sync_detect) n_sync++;
      if (bus.stuff_err)   n_err++;
      if (bus.frame_done)  n_fd++;
      if (mon_en) begin
        if (bus.data_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("rand_unexpected_word", 1, 0);
          end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check_eq("rand_word", {16'h0, bus.data_out}, {16'h0, e[15:0]});
            check_eq("rand_frame_done", {31'h0, bus.frame_done}, {31'h0, e[16]});
          end
        end else if (bus.frame_done) begin
          check_eq("rand_lone_frame_done", 1, 0);
        end
        if (bus.stuff_err) check_eq("rand_stuff_err", 1, 0);
      end
    end
  end

  // Line driver; NRZI-encodes when the DUT is built with the decoder.
  logic line_lvl = 1'b1;
  logic bit_q[$];
  int   run = 0;

  task automatic send_bit(input logic b);
    logic l;
`ifdef USB_RX_NRZI_DECODE_EN
    l = b ? line_lvl : ~line_lvl;
    line_lvl = l;
`else
    l = b;
`endif
    bus.serial_in    = l;
    bus.serial_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap_cycle();
    bus.serial_valid = 1'b0;
    bus.serial_in    = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'b0111_1110;
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
    run = 0;
  endtask

  // Transmit-side view: every data bit goes out, a 0 follows any six 1s.
  function automatic void enc_word(input logic [15:0] w, input logic stuff_on);
    for (int i = 0; i < 16; i++) begin
      bit_q.push_back(w[i]);
      run = w[i] ? run + 1 : 0;
      if (stuff_on && run == 6) begin
        bit_q.push_back(1'b0);
        run = 0;
      end
    end
  endfunction

  task automatic word_check(input logic [15:0] w, input int exp_len, input string tag);
    int n, at;
    n = 0;
    at = 0;
    enc_word(w, stuff_oper);
    while (bit_q.size() > 0) begin
      send_bit(bit_q.pop_front());
      n++;
      if (bus.data_valid && at == 0) at = n;
    end
    check_eq({tag, "_latency_bits"}, at, exp_len);
    check_eq({tag, "_data"}, {16'h0, bus.data_out}, {16'h0, w});
  endtask

  task automatic play(input int gap_pct);
    while (bit_q.size() > 0) begin
      if ($urandom_range(99) < gap_pct) gap_cycle();
      else send_bit(bit_q.pop_front());
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_busy", {31'h0, bus.busy}, 0);
    check_eq("rst_data_out", {16'h0, bus.data_out}, 0);
    check_eq("rst_pulses", {28'h0, bus.data_valid, bus.sync_detect, bus.stuff_err, bus.frame_done}, 0);
    bus.serial_valid = 1'b0;
    line_lvl = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d_dv, d_sync, d_err, d_fd;
    logic [15:0] w;
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("por_busy", {31'h0, bus.busy}, 0);
    check_eq("por_data_out", {16'h0, bus.data_out}, 0);
    rst = 1'b1;

    // SYNC followed by two words
    stuff_oper = 1'b1;
    repeat (3) send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check_eq("sync_early", {31'h0, bus.sync_detect}, 0);
    send_bit(1'b0);
    check_eq("sync_pulse", {31'h0, bus.sync_detect}, 1);
    check_eq("sync_busy", {31'h0, bus.busy}, 1);
    run = 0;
    word_check(16'hA5C3, 16, "w0");
    word_check(16'h5A3C, 16, "w1");

    // Reset mid-stream, then quiet idle
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    d_dv = n_dv; d_sync = n_sync; d_err = n_err; d_fd = n_fd;
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    check_eq("idle_pulses", (n_dv - d_dv) + (n_sync - d_sync) + (n_err - d_err) + (n_fd - d_fd), 0);
    check_eq("idle_busy", {31'h0, bus.busy}, 0);

    // Stuffed zero after six 1s is removed
    send_sync();
    d_err = n_err;
    word_check(16'h003F, 17, "stuffed");
    check_eq("stuffed_no_err", n_err - d_err, 0);

    // Seventh consecutive 1 is a stuffing violation
    do_reset();
    send_sync();
    d_dv = n_dv;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check_eq("err_early", {31'h0, bus.stuff_err}, 0);
    send_bit(1'b1);
    check_eq("err_pulse", {31'h0, bus.stuff_err}, 1);
    check_eq("err_busy", {31'h0, bus.busy}, 0);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    check_eq("err_no_word", n_dv - d_dv, 0);
    send_sync();
    check_eq("err_resync", {31'h0, bus.sync_detect}, 1);

    // Destuffing disabled: a run of sixteen 1s is plain data
    do_reset();
    stuff_oper = 1'b0;
    send_sync();
    d_err = n_err;
    word_check(16'hFFFF, 16, "nostuff");
    send_bit(1'b1);
    check_eq("nostuff_no_err", n_err - d_err, 0);

    // Random frames with gaps in serial_valid
    do_reset();
    d_dv = n_dv; d_sync = n_sync; d_err = n_err; d_fd = n_fd;
    mon_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      stuff_oper = 1'($urandom);
      repeat ($urandom_range(2, 6)) bit_q.push_back(1'b0);
      play(30);
      send_sync();
      for (int k = 0; k < WPF; k++) begin
        w = 16'($urandom);
        if ($urandom_range(2) == 0) w = w | (16'h0FC0 << $urandom_range(0, 6));
        exp_q.push_back({(k == WPF - 1) ? 1'b1 : 1'b0, w});
        enc_word(w, stuff_oper);
      end
      play(30);
    end
    repeat (10) send_bit(1'b0);
    check_eq("rand_queue_empty", exp_q.size(), 0);
    check_eq("rand_sync_count", n_sync - d_sync, 30);
    check_eq("rand_word_count", n_dv - d_dv, 30 * WPF);
    check_eq("rand_frame_count", n_fd - d_fd, 30);
    check_eq("rand_err_count", n_err - d_err, 0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_bit_destuff_rx.md
Name: usb_bit_destuff_rx

Overview:
- Receive-side counterpart of the serial transmitter: consumes the encoded serial bit stream and produces 16-bit parallel words.
- Hunts for the SYNC byte 0111_1110, then removes stuffed zeros (a 0 inserted after six consecutive 1s).
- Assembles the remaining bits LSB-first into words and flags stuffing violations.
- Sits directly downstream of the transmitter's serial output (loopback in bench) and upstream of the packet/opcode decode logic.

Parameters:
- DATA_W, 16, width of an assembled word.
- WORDS_PER_FRAME, 4, number of words accepted after one SYNC before returning to hunt.
- SYNC_PAT, 8'b0111_1110, SYNC byte compared against the hunt shift register.
- STUFF_RUN, 6, consecutive 1s after which the next bit is a stuffed bit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- serial_in  input  1  received line bit
- serial_valid  input  1  serial_in is sampled only on edges where this is high
- STUFF_OPER_rx  input  1  1 = destuffing enabled; 0 = every bit is data
- data_out  output  DATA_W  last completed word, LSB = first received data bit
- data_valid  output  1  one-cycle pulse, data_out updated
- sync_detect  output  1  one-cycle pulse on SYNC match
- stuff_err  output  1  one-cycle pulse on stuffing violation
- frame_done  output  1  one-cycle pulse with the last word of a frame
- busy  output  1  high while in DATA state

Behaviour:
- Reset (rst=0, async):
  - State HUNT; hunt shift register, ones_cnt, bit_idx, word_cnt and data_out all 0.
  - All pulse outputs 0; busy 0.
- rst has priority over all other events. Reset mid-frame discards the partial word; no pulse is emitted.
- No state, counter or register changes on edges with serial_valid=0. Pulse outputs deassert on the next edge regardless of serial_valid.
- HUNT:
  - On each sampled bit, shift left with the new bit into bit 0.
  - When the post-shift value equals SYNC_PAT: pulse sync_detect, go to DATA.
  - On that transition clear ones_cnt, bit_idx, word_cnt and the hunt register.
- DATA (busy=1):
  - ones_cnt counts consecutive sampled 1s and saturates at STUFF_RUN. A 0 clears it.
  - With STUFF_OPER_rx=1 and ones_cnt==STUFF_RUN, the current bit is a stuff position:
    - 0: discard the bit (no bit_idx advance) and clear ones_cnt.
    - 1: pulse stuff_err, discard the partial word, clear counters, go to HUNT.
  - Otherwise the bit is written to word bit[bit_idx] and bit_idx increments.
  - When bit_idx wraps DATA_W-1 to 0:
    - data_out is loaded (complete word, including the current bit) at that same edge.
    - data_valid is high for the following cycle. Latency: 1 clk after the edge sampling the last data bit.
    - word_cnt increments.
  - ones_cnt carries across word boundaries; a stuffed bit may follow the last bit of a word.
  - When word_cnt reaches WORDS_PER_FRAME: frame_done pulses coincident with that data_valid, then go to HUNT (counters cleared).
  - SYNC_PAT appearing in the data stream while in DATA is treated as data; it is not re-detected.
- With STUFF_OPER_rx=0, ones_cnt still tracks the run, but no bit is dropped and stuff_err never fires.
- data_out holds its value between data_valid pulses.

Optional Feature:
- Macro USB_RX_NRZI_DECODE_EN.
- Defined:
  - A stage in front of all logic decodes NRZI: decoded bit = 1 when serial_in equals the previous sampled line level, else 0.
  - The previous-level register resets to 1 (idle J) and updates only on serial_valid.
  - Adds no latency; the decode is combinational on the registered previous level.
- Undefined: serial_in is used directly as the data bit.

Decomposition:
- Package usb_rx_pkg holds:
  - the state enum (HUNT, DATA),
  - the SYNC_PAT constant 8'b0111_1110,
  - STUFF_RUN,
  - the ones_cnt width constant (3 bits).
- One sub-module, usb_nrzi_decoder, is natural: 1-bit in/out with a valid qualifier, instantiated only under USB_RX_NRZI_DECODE_EN.
- Destuffing and word assembly stay in the top.

Test Plan:
1. Reset: drive rst=0 mid-stream, then release → all outputs 0, busy 0, state HUNT; no pulses for 20 idle cycles.
2. SYNC then two words, STUFF_OPER_rx=1: send 0111_1110 then 16'hA5C3 LSB-first → sync_detect after the 8th bit, data_valid with data_out=16'hA5C3.
3. Stuff removal: send SYNC, then word 16'h003F with a 0 inserted after bit 5 (17 line bits) → data_out=16'h003F, 17 sampled bits to data_valid.
4. Stuff error: after SYNC send seven consecutive 1s → stuff_err pulses on the 7th; busy drops; no data_valid; a subsequent SYNC is re-detected.
5. Frame length and gaps: WORDS_PER_FRAME=4 with serial_valid toggling randomly → exactly 4 data_valid pulses, frame_done with the 4th; words match the sent values.
6. STUFF_OPER_rx=0: send SYNC then 16'hFFFF (no stuffed bit) → data_out=16'hFFFF and no stuff_err.
